// File: rtl/addition_stage2_align.sv
// FP adder stage 2: right-aligns the smaller operand's mantissa by |exp_diff|, SHIFT_STEP bits per cycle.
// Define ALIGN_STICKY_EN to keep the sticky bit; otherwise aligned_mantissa_out[0] is tied to 0.
module addition_stage2_align #(
    parameter int MENT_WIDTH = 23,
    parameter int EXPO_WIDTH = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [EXPO_WIDTH:0]   exp_diff_in,
    input  logic [MENT_WIDTH-1:0] smaller_operand_in,
    input  logic                  smaller_normal_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [MENT_WIDTH+3:0] aligned_mantissa_out
);
    localparam int W  = MENT_WIDTH + 3;
    localparam int CW = $clog2(W + 1);
    localparam logic [EXPO_WIDTH:0] W_MAG  = (EXPO_WIDTH + 1)'(W);
    localparam logic [CW-1:0]       W_CNT  = CW'(W);
    localparam logic [CW-1:0]       STEP_C = CW'(SHIFT_STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    shreg_q;
    logic [CW-1:0]   remaining_q;
    logic            valid_q;
    logic [W:0]      result_q;

    logic [EXPO_WIDTH:0] mag;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       s;
    logic                sticky_bit;

    // Unsigned magnitude: the most negative difference (9'h100) reads as 256.
    assign mag = exp_diff_in[EXPO_WIDTH] ? -exp_diff_in : exp_diff_in;
    assign cnt = (mag >= W_MAG) ? W_CNT : CW'(mag);
    assign s   = (remaining_q < STEP_C) ? remaining_q : STEP_C;

`ifdef ALIGN_STICKY_EN
    logic [W-1:0] lost_bits;
    logic         sticky_q;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lost
            assign lost_bits[gi] = shreg_q[gi] & (CW'(gi) < s);
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sticky_q <= 1'b0;
        end else if (state_q == IDLE && valid_in) begin
            sticky_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            sticky_q <= sticky_q | (|lost_bits);
        end
    end

    assign sticky_bit = sticky_q;
`else
    assign sticky_bit = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        shreg_q     <= {smaller_normal_in, smaller_operand_in, 2'b00};
                        remaining_q <= cnt;
                        state_q     <= (cnt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q     <= shreg_q >> s;
                    remaining_q <= remaining_q - s;
                    if (remaining_q == s) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the handshake.
                    if (!valid_q) begin
                        valid_q  <= 1'b1;
                        result_q <= {shreg_q, sticky_bit};
                    end else if (ready_in) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_out            = (state_q == IDLE) && !rst_in;
    assign valid_out            = valid_q;
    assign aligned_mantissa_out = result_q;
endmodule
